// File: rtl/eth_frame_echo.sv
// eth_frame_echo: buffers one received Ethernet frame and echoes it back to the sender
//   when the destination MAC and EtherType match. In the echo, the destination becomes the
//   rx source and the source becomes LOCAL_MAC; all other bytes are copied unchanged.
// Ports:
//   clk, rst_n                    logic clock, asynchronous active-low reset
//   rx_axis_t{data,valid,ready,last,user}  MAC rx stream (FCS already stripped, tuser = frame error)
//   tx_axis_t{data,valid,ready,last,user}  echo stream towards the MAC (tuser always 0)
//   frames_echoed, frames_dropped          saturating frame counters
//   busy                                   high while an echo frame is being transmitted
module eth_frame_echo #(
   parameter int          MAX_FRAME_BYTES = 1536,
   parameter logic [47:0] LOCAL_MAC       = 48'h02_00_00_00_00_01,
   parameter logic [15:0] ECHO_ETHERTYPE  = 16'h88B5,
   parameter bit          ACCEPT_BCAST    = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_axis_tdata,
   input  logic        rx_axis_tvalid,
   output logic        rx_axis_tready,
   input  logic        rx_axis_tlast,
   input  logic        rx_axis_tuser,
   output logic [7:0]  tx_axis_tdata,
   output logic        tx_axis_tvalid,
   input  logic        tx_axis_tready,
   output logic        tx_axis_tlast,
   output logic        tx_axis_tuser,
   output logic [15:0] frames_echoed,
   output logic [15:0] frames_dropped,
   output logic        busy
);
   localparam int LW = $clog2(MAX_FRAME_BYTES + 1);
   localparam int AW = $clog2(MAX_FRAME_BYTES);
   localparam logic [LW-1:0] MAX_LEN = LW'(MAX_FRAME_BYTES);

   typedef enum logic [1:0] {IDLE, RX, TX, DROP} state_t;
   state_t state, state_nx;

   // Byte i (0 = most significant) of a 48-bit MAC address.
   function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [3:0] i);
      logic [47:0] sh;
      sh = mac << {i, 3'b000};
      return sh[47:40];
   endfunction

   logic [7:0]    mem [MAX_FRAME_BYTES];
   logic [7:0]    rd_data;
   logic [LW-1:0] len, tx_len, f_idx, rd_idx;
   logic [47:0]   peer_mac;
   logic          uc_ok, bc_ok, ty_ok;
   logic          uc_nx, bc_nx, ty_nx, match;
   logic          rd_ok;
   logic          rx_hs, tx_hs, at_max, go_tx, drop_evt, fetch, load;
   logic [7:0]    out_byte;

   assign rx_axis_tready = (state == RX) || (state == DROP);
   assign tx_axis_tuser  = 1'b0;
   assign busy           = (state == TX);

   always_comb begin
      rx_hs  = rx_axis_tvalid && rx_axis_tready;
      tx_hs  = tx_axis_tvalid && tx_axis_tready;
      at_max = (len == MAX_LEN);
      // Match flags restart on the first byte of every frame and only ever clear afterwards.
      uc_nx  = (len == '0 || uc_ok) && (len > 5 || rx_axis_tdata == mac_byte(LOCAL_MAC, len[3:0]));
      bc_nx  = (len == '0 || bc_ok) && (len > 5 || rx_axis_tdata == 8'hFF);
      ty_nx  = (len == '0 || ty_ok) &&
               (len == 12 ? rx_axis_tdata == ECHO_ETHERTYPE[15:8] :
                len == 13 ? rx_axis_tdata == ECHO_ETHERTYPE[7:0] : 1'b1);
      match  = (uc_nx || (ACCEPT_BCAST && bc_nx)) && ty_nx;
      // A frame of MAX_LEN+1 bytes ends with tlast at len==MAX_LEN and is too long to keep.
      go_tx  = (state == RX) && rx_hs && rx_axis_tlast && !at_max && !rx_axis_tuser &&
               (len >= 13) && match;
      drop_evt = rx_hs && rx_axis_tlast && (((state == RX) && !go_tx) || (state == DROP));
      // Two-stage output pipeline: fetch reads the buffer, load moves the result to the tx register.
      load   = (state == TX) && rd_ok && (!tx_axis_tvalid || tx_axis_tready);
      fetch  = (state == TX) && (!rd_ok || load) && (f_idx < tx_len);
      out_byte = rd_idx < 6  ? mac_byte(peer_mac, rd_idx[3:0]) :
                 rd_idx < 12 ? mac_byte(LOCAL_MAC, rd_idx[3:0] - 4'd6) : rd_data;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = RX;
         RX:   state_nx = go_tx ? TX : (rx_hs && at_max && !rx_axis_tlast) ? DROP : RX;
         DROP: state_nx = (rx_hs && rx_axis_tlast) ? RX : DROP;
         TX:   state_nx = (tx_hs && tx_axis_tlast) ? RX : TX;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_ff @(posedge clk) begin
      if ((state == RX) && rx_hs && !at_max) mem[len[AW-1:0]] <= rx_axis_tdata;
      if (fetch) rd_data <= mem[f_idx[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len            <= '0;
         tx_len         <= '0;
         f_idx          <= '0;
         rd_idx         <= '0;
         rd_ok          <= 1'b0;
         peer_mac       <= '0;
         uc_ok          <= 1'b0;
         bc_ok          <= 1'b0;
         ty_ok          <= 1'b0;
         tx_axis_tdata  <= '0;
         tx_axis_tvalid <= 1'b0;
         tx_axis_tlast  <= 1'b0;
         frames_echoed  <= '0;
         frames_dropped <= '0;
      end else begin
         if ((state == RX) && rx_hs) begin
            len   <= (rx_axis_tlast || at_max) ? '0 : len + 1'b1;
            uc_ok <= uc_nx;
            bc_ok <= bc_nx;
            ty_ok <= ty_nx;
            if (len > 5 && len < 12) peer_mac <= {peer_mac[39:0], rx_axis_tdata};
         end
         if (go_tx) begin
            tx_len <= len + 1'b1;
            f_idx  <= '0;
            rd_ok  <= 1'b0;
         end else if (fetch) begin
            f_idx  <= f_idx + 1'b1;
            rd_idx <= f_idx;
            rd_ok  <= 1'b1;
         end else if (load) begin
            rd_ok  <= 1'b0;
         end
         if (load) begin
            tx_axis_tvalid <= 1'b1;
            tx_axis_tdata  <= out_byte;
            tx_axis_tlast  <= (rd_idx == tx_len - 1'b1);
         end else if (tx_hs) begin
            tx_axis_tvalid <= 1'b0;
            tx_axis_tlast  <= 1'b0;
         end
         if (tx_hs && tx_axis_tlast)
            frames_echoed <= frames_echoed + {15'd0, frames_echoed != 16'hFFFF};
         if (drop_evt)
            frames_dropped <= frames_dropped + {15'd0, frames_dropped != 16'hFFFF};
      end
   end
endmodule

// File: tb/tb_eth_frame_echo.sv
// tb_eth_frame_echo: scoreboard bench for eth_frame_echo with a frame-level reference model.
module tb_eth_frame_echo;
   localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
   localparam logic [47:0] PEER  = 48'h0A_0B_0C_0D_0E_0F;
   localparam logic [15:0] ETYPE = 16'h88B5;
   localparam int          MAXB  = 64;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [7:0] rx_data = '0, tx_data;
   logic rx_valid = 1'b0, rx_ready, rx_last = 1'b0, rx_user = 1'b0;
   logic tx_valid, tx_ready = 1'b1, tx_last, tx_user, busy;
   logic [15:0] echoed, dropped;

   eth_frame_echo #(.MAX_FRAME_BYTES(MAXB)) dut (
      .clk(clk), .rst_n(rst_n),
      .rx_axis_tdata(rx_data), .rx_axis_tvalid(rx_valid), .rx_axis_tready(rx_ready),
      .rx_axis_tlast(rx_last), .rx_axis_tuser(rx_user),
      .tx_axis_tdata(tx_data), .tx_axis_tvalid(tx_valid), .tx_axis_tready(tx_ready),
      .tx_axis_tlast(tx_last), .tx_axis_tuser(tx_user),
      .frames_echoed(echoed), .frames_dropped(dropped), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int exp_echo = 0, exp_drop = 0, rdy_pct = 100, mon_n = 0;
   logic [8:0] exp_q[$];
   logic [7:0] frm[$];
   logic pv = 1'b0;
   logic [8:0] pd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] mb(input logic [47:0] m, input int i);
      return m[47-8*i -: 8];
   endfunction

   task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] ty,
                        input int n, input bit rnd);
      frm.delete();
      for (int i = 0; i < n; i++)
         frm.push_back(i < 6 ? mb(dst, i) : i < 12 ? mb(src, i - 6) : i == 12 ? ty[15:8] :
                       i == 13 ? ty[7:0] : rnd ? 8'($urandom) : 8'(i - 14));
   endtask

   // Reference model: decides the fate of the frame in frm and queues the expected echo.
   task automatic model(input bit tu);
      int n = frm.size();
      logic [47:0] dst = '0;
      bit ok = 1'b0;
      if (n >= 14) begin
         for (int i = 0; i < 6; i++) dst = {dst[39:0], frm[i]};
         ok = !tu && n <= MAXB && (dst == LOCAL || dst == '1) && {frm[12], frm[13]} == ETYPE;
      end
      if (ok) begin
         for (int i = 0; i < n; i++)
            exp_q.push_back({i == n - 1, i < 6 ? frm[i + 6] : i < 12 ? mb(LOCAL, i - 6) : frm[i]});
         exp_echo++;
      end else exp_drop++;
   endtask

   task automatic send(input bit tu, input bit gap, output int stalls);
      stalls = 0;
      foreach (frm[i]) begin
         int w;
         @(negedge clk);
         if (gap && $urandom_range(0, 3) == 0) begin
            rx_valid = 1'b0;
            @(negedge clk);
         end
         rx_data = frm[i];
         rx_last = (i == frm.size() - 1);
         rx_user = tu && rx_last;
         rx_valid = 1'b1;
         w = 0;
         while (!rx_ready) begin
            stalls++;
            w++;
            if (w > 5000) begin
               total++;
               bad++;
               $display("FAIL rx_stall: tready low for %0d clks, want a handshake", w);
               rx_valid = 1'b0;
               return;
            end
            @(negedge clk);
         end
         @(posedge clk);
      end
      #1;
      rx_valid = 1'b0;
      rx_last = 1'b0;
      rx_user = 1'b0;
   endtask

   task automatic frame(input bit tu, input bit gap);
      int s;
      model(tu);
      send(tu, gap, s);
   endtask

   task automatic wait_idle(input string name);
      for (int c = 0; ; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy && !tx_valid) break;
         if (c > 4000) begin
            total++;
            bad++;
            $display("FAIL %s_drain: %0d bytes still expected, want 0", name, exp_q.size());
            exp_q.delete();
            break;
         end
      end
      chk({name, "_echoed"}, 32'(echoed), 32'(exp_echo));
      chk({name, "_dropped"}, 32'(dropped), 32'(exp_drop));
   endtask

   always @(posedge clk) begin
      #2;
      tx_ready = ($urandom_range(0, 99) < rdy_pct);
   end

   // Monitor: AXIS hold rule, rx backpressure during TX, and scoreboard comparison.
   always @(negedge clk) begin
      if (!rst_n) pv = 1'b0;
      else begin
         if (pv) chk("tx_hold", {tx_valid, tx_last, tx_data}, {1'b1, pd});
         if (busy) chk("rx_ready_in_tx", 32'(rx_ready), 32'd0);
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) chk("tx_unexpected", {tx_last, tx_data}, 32'h1FF);
            else chk("tx_byte", {tx_user, tx_last, tx_data}, {1'b0, exp_q.pop_front()});
            mon_n = tx_last ? 0 : mon_n + 1;
         end
         pv = tx_valid && !tx_ready;
         pd = {tx_last, tx_data};
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s;
      repeat (3) @(negedge clk);
      chk("rst_outputs", {tx_valid, rx_ready, busy, tx_last, tx_user, tx_data}, 32'd0);
      chk("rst_counters", {echoed, dropped}, 32'd0);
      rst_n = 1'b1;

      build(LOCAL, PEER, ETYPE, 64, 1'b0); frame(1'b0, 1'b0); wait_idle("t1");

      build('1, PEER, ETYPE, 60, 1'b1); frame(1'b0, 1'b0); wait_idle("t2_bcast");
      build(48'h02_00_00_00_00_02, PEER, ETYPE, 60, 1'b1); frame(1'b0, 1'b0); wait_idle("t2_dst");
      build(LOCAL, PEER, 16'h0800, 60, 1'b1); frame(1'b0, 1'b0); wait_idle("t2_type");

      build(LOCAL, PEER, ETYPE, 64, 1'b1); frame(1'b1, 1'b0); wait_idle("t3_tuser");
      build(LOCAL, PEER, ETYPE, 10, 1'b1); frame(1'b0, 1'b0); wait_idle("t3_runt");
      build(LOCAL, PEER, ETYPE, 13, 1'b1); frame(1'b0, 1'b0); wait_idle("t3_13b");
      build(LOCAL, PEER, ETYPE, 14, 1'b1); frame(1'b0, 1'b0); wait_idle("t3_14b");

      build(LOCAL, PEER, ETYPE, 100, 1'b1); model(1'b0); send(1'b0, 1'b0, s);
      chk("t4_no_stall", 32'(s), 32'd0);
      wait_idle("t4_long");
      build(LOCAL, PEER, ETYPE, 65, 1'b1); frame(1'b0, 1'b0); wait_idle("t4_65b");
      build(LOCAL, PEER, ETYPE, 64, 1'b1); frame(1'b0, 1'b0); wait_idle("t4_64b");

      rdy_pct = 50;
      build(LOCAL, PEER, ETYPE, 64, 1'b0); frame(1'b0, 1'b0); wait_idle("t5_stall");
      build(LOCAL, 48'h11_22_33_44_55_66, ETYPE, 40, 1'b1); frame(1'b0, 1'b0);
      build('1, 48'hA1_A2_A3_A4_A5_A6, ETYPE, 50, 1'b1); frame(1'b0, 1'b0);
      wait_idle("t5_b2b");

      rdy_pct = 70;
      for (int k = 0; k < 24; k++) begin
         int r = $urandom_range(0, 3);
         build(r < 2 ? LOCAL : r == 2 ? '1 : 48'h02_00_00_00_00_02, 48'({$urandom, $urandom}),
               $urandom_range(0, 3) != 0 ? ETYPE : 16'h0800, $urandom_range(10, 72), 1'b1);
         frame($urandom_range(0, 7) == 0, 1'b1);
      end
      wait_idle("rand");

      rdy_pct = 100;
      build(LOCAL, PEER, ETYPE, 64, 1'b1); frame(1'b0, 1'b0);
      for (int c = 0; mon_n < 20; c++) begin
         @(negedge clk);
         if (c > 500) begin
            chk("t6_reach_byte20", 32'(mon_n), 32'd20);
            break;
         end
      end
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_tvalid_async", 32'(tx_valid), 32'd0);
      chk("t6_counters", {echoed, dropped}, 32'd0);
      exp_q.delete();
      exp_echo = 0;
      exp_drop = 0;
      mon_n = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      build(LOCAL, 48'h0C_0D_0E_0F_10_11, ETYPE, 64, 1'b1); frame(1'b0, 1'b0); wait_idle("t6_after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
